// File: rtl/ac_pkg.sv
// ac_pkg: opcodes, rotate-FSM states and {E,Q} rotate helpers for the accumulator.
package ac_pkg;
  localparam int AC_XW = 64;
  typedef enum logic [3:0] {
    AC_OP_NOP  = 4'd0,
    AC_OP_LD   = 4'd1,
    AC_OP_INC  = 4'd2,
    AC_OP_CLA  = 4'd3,
    AC_OP_CLE  = 4'd4,
    AC_OP_CMA  = 4'd5,
    AC_OP_CME  = 4'd6,
    AC_OP_ADD  = 4'd7,
    AC_OP_AND  = 4'd8,
    AC_OP_CIR  = 4'd9,
    AC_OP_CIL  = 4'd10,
    AC_OP_CIRN = 4'd11,
    AC_OP_CILN = 4'd12
  } ac_op_e;
  typedef enum logic {ST_IDLE, ST_ROT} ac_st_e;
  // Rotate the low n bits of x ({E,Q} zero-extended) by one place.
  function automatic logic [AC_XW-1:0] rot_r(input logic [AC_XW-1:0] x, input int n);
    logic [AC_XW-1:0] m;
    m = (AC_XW'(1) << n) - AC_XW'(1);
    return ((x >> 1) | (AC_XW'(x[0]) << (n - 1))) & m;
  endfunction
  function automatic logic [AC_XW-1:0] rot_l(input logic [AC_XW-1:0] x, input int n);
    logic [AC_XW-1:0] m;
    m = (AC_XW'(1) << n) - AC_XW'(1);
    return ((x << 1) | AC_XW'(x[n-1])) & m;
  endfunction
endpackage

// File: rtl/ac_rot_seq.sv
// ac_rot_seq: IDLE/ROT counter FSM pacing the multi-cycle rotate-by-N.
module ac_rot_seq
  import ac_pkg::*;
#(
  parameter int SHAMT_W = 4
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               i_start,
  input  logic               i_dir,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic               o_step_en,
  output logic               o_dir,
  output logic               o_busy,
  output logic               o_done_rot
);
  ac_st_e             r_st, w_st_nxt;
  logic [SHAMT_W-1:0] r_cnt, w_cnt_nxt;
  logic               r_dir, w_dir_nxt;
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_st  <= ST_IDLE;
      r_cnt <= '0;
      r_dir <= 1'b0;
    end else begin
      r_st  <= w_st_nxt;
      r_cnt <= w_cnt_nxt;
      r_dir <= w_dir_nxt;
    end
  end
  always_comb begin
    w_st_nxt  = r_st;
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    if (r_st == ST_IDLE && i_start) begin
      w_st_nxt  = ST_ROT;
      w_cnt_nxt = i_shamt;
      w_dir_nxt = i_dir;
    end else if (r_st == ST_ROT) begin
      w_cnt_nxt = r_cnt - SHAMT_W'(1);
      w_st_nxt  = (r_cnt == SHAMT_W'(1)) ? ST_IDLE : ST_ROT;
    end
  end
  assign o_busy     = (r_st == ST_ROT);
  assign o_step_en  = o_busy;
  assign o_dir      = r_dir;
  assign o_done_rot = o_busy && (r_cnt == SHAMT_W'(1));
endmodule

// File: rtl/ac_alu_reg.sv
// ac_alu_reg: WIDTH-bit accumulator with extend bit, ALU ops and rotate-by-N sequencer.
// Define AC_OVF_FLAG_EN to add the sticky overflow output V.
module ac_alu_reg
  import ac_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic [3:0]         OP,
  input  logic               OP_VALID,
  input  logic [WIDTH-1:0]   DATA,
  input  logic [SHAMT_W-1:0] SHAMT,
  output logic [WIDTH-1:0]   Q,
  output logic               E,
  output logic               BUSY,
  output logic               DONE,
  output logic               ZERO,
  output logic               NEG
`ifdef AC_OVF_FLAG_EN
  ,
  output logic               V
`endif
);
  logic [WIDTH-1:0] r_q, w_inc;
  logic             r_e, r_done;
  logic [WIDTH:0]   w_nxt, w_sum, w_rr, w_rl;
  logic [AC_XW-1:0] w_ex;
  logic             w_acc, w_rot_start, w_step, w_dir, w_busy, w_last;
  assign w_acc       = OP_VALID && !w_busy;
  assign w_rot_start = w_acc && (OP == AC_OP_CIRN || OP == AC_OP_CILN) && (SHAMT != '0);
  assign w_ex        = AC_XW'({r_e, r_q});
  assign w_rr        = (WIDTH+1)'(rot_r(w_ex, WIDTH + 1));
  assign w_rl        = (WIDTH+1)'(rot_l(w_ex, WIDTH + 1));
  assign w_sum       = {1'b0, r_q} + {1'b0, DATA};
  assign w_inc       = r_q + WIDTH'(1);
  ac_rot_seq #(.SHAMT_W(SHAMT_W)) u_seq (
    .CLK       (CLK),
    .CLR       (CLR),
    .i_start   (w_rot_start),
    .i_dir     (OP == AC_OP_CILN),
    .i_shamt   (SHAMT),
    .o_step_en (w_step),
    .o_dir     (w_dir),
    .o_busy    (w_busy),
    .o_done_rot(w_last)
  );
  always_comb begin
    w_nxt = {r_e, r_q};
    if (w_step) w_nxt = w_dir ? w_rl : w_rr;
    else if (w_acc)
      case (OP)
        AC_OP_LD:  w_nxt = {r_e, DATA};
        AC_OP_INC: w_nxt = {r_e, w_inc};
        AC_OP_CLA: w_nxt = {r_e, {WIDTH{1'b0}}};
        AC_OP_CLE: w_nxt = {1'b0, r_q};
        AC_OP_CMA: w_nxt = {r_e, ~r_q};
        AC_OP_CME: w_nxt = {~r_e, r_q};
        AC_OP_ADD: w_nxt = w_sum;
        AC_OP_AND: w_nxt = {r_e, r_q & DATA};
        AC_OP_CIR: w_nxt = w_rr;
        AC_OP_CIL: w_nxt = w_rl;
        default:   w_nxt = {r_e, r_q};
      endcase
  end
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_q    <= '0;
      r_e    <= 1'b0;
      r_done <= 1'b0;
    end else begin
      {r_e, r_q} <= w_nxt;
      r_done     <= (w_acc && !w_rot_start) || w_last;
    end
  end
`ifdef AC_OVF_FLAG_EN
  logic r_v, w_v_set, w_v_clr;
  assign w_v_set = w_acc && (
      (OP == AC_OP_ADD && r_q[WIDTH-1] == DATA[WIDTH-1] && w_sum[WIDTH-1] != r_q[WIDTH-1]) ||
      (OP == AC_OP_INC && !r_q[WIDTH-1] && w_inc[WIDTH-1]));
  assign w_v_clr = w_acc && (OP == AC_OP_CLA || OP == AC_OP_LD);
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) r_v <= 1'b0;
    else     r_v <= w_v_clr ? 1'b0 : (r_v | w_v_set);
  end
  assign V = r_v;
`endif
  assign Q    = r_q;
  assign E    = r_e;
  assign BUSY = w_busy;
  assign DONE = r_done;
  assign ZERO = (r_q == '0);
  assign NEG  = r_q[WIDTH-1];
endmodule

// File: doc/ac_alu_reg.md
Name: ac_alu_reg

Overview:
- Parametrised accumulator register for the basic-computer datapath.
- Generalises the fixed 16-bit load/increment/clear accumulator to WIDTH bits.
- Adds the extend bit E, the full register-reference/ALU operation set, and a multi-cycle rotate-by-N sequencer with a BUSY/DONE handshake.
- Sits between the common bus (DATA) and the control unit (OP/OP_VALID).

Parameters:
- WIDTH, 16: accumulator width in bits, minimum 2.
- SHAMT_W, 4: width of the rotate-amount input.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- CLR  in  1  reset, asynchronous, active-high; clock is CLK.
- OP  in  4  operation code; encodings are in the Behaviour section.
- OP_VALID  in  1  OP is accepted on this edge when BUSY=0.
- DATA  in  WIDTH  bus operand, used by LD/ADD/AND.
- SHAMT  in  SHAMT_W  rotate count for CIRN/CILN, sampled at acceptance.
- Q  out  WIDTH  accumulator contents.
- E  out  1  extend/carry bit.
- BUSY  out  1  multi-cycle rotate in progress.
- DONE  out  1  one-cycle pulse, operation completed.
- ZERO  out  1  combinational, Q==0.
- NEG  out  1  combinational, Q[WIDTH-1].

Behaviour:
- Reset: while CLR=1, Q=0, E=0, BUSY=0, DONE=0, and the shift counter is 0. CLR overrides any op, including a rotate mid-sequence, which is abandoned with no DONE pulse.
- Opcodes and their effect on acceptance edge (OP_VALID=1, BUSY=0):
  - 0 NOP: no change.
  - 1 LD: Q<=DATA.
  - 2 INC: Q<=Q+1 modulo 2^WIDTH; E unchanged.
  - 3 CLA: Q<=0.
  - 4 CLE: E<=0.
  - 5 CMA: Q<=~Q.
  - 6 CME: E<=~E.
  - 7 ADD: {E,Q}<=Q+DATA, with WIDTH+1-bit result; E takes the carry-out.
  - 8 AND: Q<=Q&DATA; E unchanged.
  - 9 CIR: Q<={E,Q[W-1:1]} and E<=Q[0].
  - 10 CIL: Q<={Q[W-2:0],E} and E<=Q[W-1].
  - 11 CIRN and 12 CILN: multi-cycle rotate; see the state machine below.
  - 13–15: reserved; treated as NOP but still produce DONE.
- Single-cycle ops (0–10, 13–15): DONE=1 for the one cycle immediately after the acceptance edge, coincident with the updated Q/E. BUSY stays 0.
- State machine, states IDLE and ROT:
  - IDLE accepting CIRN/CILN with SHAMT=0: stays IDLE, no change to Q/E, DONE pulses the next cycle.
  - IDLE accepting CIRN/CILN with SHAMT=N>0: goes to ROT with cnt<=N and the direction latched. BUSY=1 starting the cycle after acceptance.
  - ROT: each edge performs one CIR or CIL step and decrements cnt.
  - On the edge that performs the final step (cnt==1): go to IDLE; BUSY<=0 and DONE<=1.
  - Total: N edges after acceptance, with the Q/E result and DONE visible together.
- OP_VALID while BUSY=1 is ignored; no queueing. Control must hold the op until BUSY=0.
- DATA and SHAMT are not used after the acceptance edge.
- DONE is never asserted for two consecutive cycles from a single op. Back-to-back single-cycle ops produce consecutive DONE pulses, one per op.

Optional Feature:
- Macro: AC_OVF_FLAG_EN.
- With the macro defined:
  - Adds output V (1 bit, reset 0), a sticky two's-complement overflow flag.
  - V is set by ADD when operand signs match and the result sign differs.
  - V is set by INC when Q goes from 0111…1 to 1000…0.
  - V is cleared only by CLR, CLA, or LD.
- Without the macro: no V port, no overflow logic; all other behaviour is identical.

Decomposition:
- Shared package ac_pkg holds:
  - the opcode localparams/enum (AC_OP_NOP … AC_OP_CILN);
  - the state enum (ST_IDLE, ST_ROT);
  - helper functions rot_r/rot_l on {E,Q}.
- One natural sub-module, ac_rot_seq: the IDLE/ROT counter FSM producing step_en, dir, BUSY, and DONE_rot. The parent holds the Q/E registers and the operation mux.

Test Plan:
- CLR pulse mid-operation → Q=0000, E=0, BUSY=0 asynchronously, before the next CLK edge.
- LD FFFF, then ADD DATA=0001 → Q=0000, E=1, ZERO=1; DONE one cycle after each op.
- LD 8001, E=0, CIRN SHAMT=3 → BUSY high for 3 cycles, OP_VALID during BUSY ignored. Final Q=5000, E=0; DONE coincides with BUSY falling.
- LD 0001, E=1, CILN SHAMT=0 → Q/E unchanged, DONE next cycle, BUSY never asserted. Then CIL → Q=0003, E=0.
- LD 7FFF, INC → Q=8000, NEG=1. With AC_OVF_FLAG_EN: V=1, stays 1 through CMA/CME, cleared by CLA.
- CMA on 00F0 → FF0F; AND DATA=0F0F → 0F0F; CME twice → E restored; opcode 14 → no change, DONE pulses.
